// File: rtl/count_seq_checker_if.sv
// Sample bus into the sequence checker: qualifier, observed count, error clear.
interface count_seq_checker_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] count_in;
    logic             err_clr;

    modport master (
        output en,
        output count_in,
        output err_clr
    );

    modport slave (
        input en,
        input count_in,
        input err_clr
    );
endinterface

// File: rtl/count_seq_checker.sv
// Locks onto a +1-per-sample counter stream and flags sequence breaks.
// Reports lock state, error pulses, saturating error and wrap counts.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    count_seq_checker_if.slave   bus,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_W-1:0]     err_count,
    output logic [ERR_W-1:0]     wrap_count,
    output logic [WIDTH-1:0]     expected
);

    localparam int GW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int BW = (LOSS_CNT < 1) ? 1 : $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  prev, prev_n;
    logic [WIDTH-1:0]  expected_n;
    logic [GW-1:0]     good_run, good_n, good_inc;
    logic [BW-1:0]     bad_run, bad_n, bad_inc;
    logic [ERR_W-1:0]  err_n, wrap_n;
    logic              pulse_n;
    logic              err_hit;
    logic              wrap_hit;
    logic              match;

    assign match    = (bus.count_in == prev + WIDTH'(1));
    assign good_inc = good_run + GW'(1);
    assign bad_inc  = bad_run + BW'(1);
    assign locked   = (state == LOCKED);

    always_comb begin
        state_n    = state;
        prev_n     = prev;
        good_n     = good_run;
        bad_n      = bad_run;
        expected_n = expected;
        pulse_n    = 1'b0;
        err_hit    = 1'b0;
        wrap_hit   = 1'b0;
        if (bus.en) begin
            prev_n     = bus.count_in;
            expected_n = bus.count_in + WIDTH'(1);
            unique case (state)
                IDLE: begin
                    good_n  = '0;
                    state_n = ACQ;
                end
                ACQ: begin
                    if (match) begin
                        good_n = good_inc;
                        if (good_inc == GW'(LOCK_CNT)) begin
                            state_n = LOCKED;
                            bad_n   = '0;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        bad_n    = '0;
                        wrap_hit = (prev == {WIDTH{1'b1}});
                    end else begin
                        pulse_n = 1'b1;
                        err_hit = 1'b1;
                        bad_n   = bad_inc;
                        if (bad_inc == BW'(LOSS_CNT)) begin
                            state_n = ACQ;
                            good_n  = '0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // A clear coinciding with a fresh error keeps that error visible.
    always_comb begin
        err_n = err_count;
        if (bus.err_clr) begin
            err_n = err_hit ? ERR_W'(1) : '0;
        end else if (err_hit && (err_count != {ERR_W{1'b1}})) begin
            err_n = err_count + ERR_W'(1);
        end
    end

    always_comb begin
        wrap_n = wrap_count;
        if (wrap_hit && (wrap_count != {ERR_W{1'b1}})) begin
            wrap_n = wrap_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            expected   <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            good_run   <= good_n;
            bad_run    <= bad_n;
            expected   <= expected_n;
            err_pulse  <= pulse_n;
            err_count  <= err_n;
            wrap_count <= wrap_n;
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: default build plus an ERR_W=2
// build sharing the same stimulus bus.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       locked, err_pulse;
    logic [7:0] err_count, wrap_count;
    logic [3:0] expected;

    logic       locked_s, pulse_s;
    logic [1:0] err_s, wrap_s;
    logic [3:0] exp_s;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    count_seq_checker_if #(.WIDTH(4)) bus ();

    count_seq_checker #(
        .WIDTH(4), .LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .wrap_count(wrap_count),
        .expected(expected)
    );

    count_seq_checker #(
        .WIDTH(4), .LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(2)
    ) dut_s (
        .clk(clk), .rst(rst), .bus(bus),
        .locked(locked_s), .err_pulse(pulse_s),
        .err_count(err_s), .wrap_count(wrap_s),
        .expected(exp_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic [3:0] v,
                        input logic clr);
        @(negedge clk);
        rst         = 1'b0;
        bus.en      = e;
        bus.count_in = v;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
        pulses += int'(err_pulse);
    endtask

    task automatic do_rst(input int n);
        repeat (n) begin
            @(negedge clk);
            rst         = 1'b1;
            bus.en      = 1'b0;
            bus.err_clr = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed_run(input logic [3:0] start, input int n);
        logic [3:0] v;
        v = start;
        for (int i = 0; i < n; i++) begin
            step(1'b1, v, 1'b0);
            v = v + 4'd1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] glitch [12];
        glitch = '{4'd9, 4'd10, 4'd0, 4'd1, 4'd7, 4'd8,
                   4'd12, 4'd13, 4'd2, 4'd3, 4'd14, 4'd15};
        bus.en       = 1'b0;
        bus.count_in = '0;
        bus.err_clr  = 1'b0;

        do_rst(2);
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_err", err_count, 0);
        chk("rst_wrap", wrap_count, 0);
        chk("rst_exp", expected, 0);

        step(1, 0, 0); chk("acq0_locked", locked, 0);
        step(1, 1, 0); chk("acq1_locked", locked, 0);
        step(1, 2, 0); chk("acq2_locked", locked, 0);
        step(1, 3, 0); chk("lock_locked", locked, 1);
        chk("lock_err", err_count, 0);
        chk("lock_exp", expected, 4);

        pulses = 0;
        feed_run(4, 9);
        feed_run(13, 5);
        chk("wrap_pulses", pulses, 0);
        chk("wrap_count", wrap_count, 1);
        chk("wrap_exp", expected, 2);
        chk("wrap_locked", locked, 1);

        feed_run(2, 3);
        step(1, 5, 0);
        step(1, 6, 0);
        step(1, 9, 0);
        chk("glitch_pulse", err_pulse, 1);
        chk("glitch_err", err_count, 1);
        chk("glitch_locked", locked, 1);
        step(1, 10, 0);
        chk("resync_pulse", err_pulse, 0);
        chk("resync_locked", locked, 1);
        step(1, 11, 0);
        chk("resync2_pulse", err_pulse, 0);
        chk("resync2_err", err_count, 1);
        chk("resync2_exp", expected, 12);

        feed_run(12, 9);
        chk("wrap2_count", wrap_count, 2);
        step(1, 5, 0); chk("loss_p0", err_pulse, 0);
        step(1, 9, 0);
        chk("loss_p1", err_pulse, 1);
        chk("loss_l1", locked, 1);
        chk("loss_e1", err_count, 2);
        step(1, 2, 0);
        chk("loss_p2", err_pulse, 1);
        chk("loss_l2", locked, 0);
        chk("loss_e2", err_count, 3);
        chk("loss_sat_s", err_s, 3);
        step(1, 3, 0); chk("reacq3", locked, 0);
        step(1, 4, 0); chk("reacq4", locked, 0);
        step(1, 5, 0); chk("reacq5", locked, 1);

        do_rst(1);
        feed_run(0, 4);
        chk("sat_lock", locked, 1);
        chk("sat_start_s", err_s, 0);
        foreach (glitch[i]) step(1, glitch[i], 0);
        chk("sat_err", err_count, 6);
        chk("sat_err_s", err_s, 3);
        chk("sat_locked", locked, 1);
        chk("sat_wrap", wrap_count, 0);
        step(1, 5, 1);
        chk("clrhit_err", err_count, 1);
        chk("clrhit_err_s", err_s, 1);
        chk("clrhit_pulse", err_pulse, 1);
        chk("clrhit_locked", locked, 1);
        step(1, 6, 0);
        step(1, 7, 1);
        chk("clr_err", err_count, 0);
        chk("clr_err_s", err_s, 0);
        chk("clr_pulse", err_pulse, 0);

        pulses = 0;
        repeat (5) step(0, 3, 0);
        chk("hold_pulses", pulses, 0);
        chk("hold_locked", locked, 1);
        chk("hold_exp", expected, 8);
        chk("hold_err", err_count, 0);
        step(1, 8, 0);
        chk("resume_pulse", err_pulse, 0);
        chk("resume_exp", expected, 9);
        feed_run(9, 8);
        chk("resume_pulses", pulses, 0);
        chk("resume_wrap", wrap_count, 1);
        step(1, 7, 0);
        chk("pre_rst_err", err_count, 1);
        step(1, 8, 0);

        do_rst(1);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_wrap", wrap_count, 0);
        chk("mid_rst_exp", expected, 0);
        feed_run(0, 3);
        chk("relock_pre", locked, 0);
        step(1, 3, 0);
        chk("relock", locked, 1);
        chk("relock_exp", expected, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
Receive-side companion to the free-running counter block. It samples a counter bus, locks onto a +1-per-sample sequence (mod 2^WIDTH), and flags every sequence break. It reports lock status, per-error pulses, a saturating error count and a wrap count. It sits downstream of any counter output, in silicon or in simulation, as a self-checking monitor.

Parameters:
WIDTH, 4, width of observed count bus
LOCK_CNT, 3, consecutive correct increments needed to declare lock (>=1)
LOSS_CNT, 2, consecutive mismatches while locked that drop lock (>=1)
ERR_W, 8, width of error and wrap counters (saturating)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  count_in valid this cycle (sample qualifier)
count_in  input  WIDTH  observed counter value
err_clr  input  1  synchronous clear of err_count
locked  output  1  high while in LOCKED state
err_pulse  output  1  one-cycle pulse: mismatch detected while locked
err_count  output  ERR_W  saturating count of mismatches while locked
wrap_count  output  ERR_W  saturating count of correct max->0 transitions while locked
expected  output  WIDTH  next value expected (prev+1 mod 2^WIDTH)

Behaviour:
- Reset (rst=1 at a clk edge, overrides all other inputs):
  - state=IDLE; locked=0, err_pulse=0, err_count=0, wrap_count=0, expected=0.
  - Internal prev, good_run and bad_run cleared.
- All outputs are registered. Each response appears after the clk edge that samples en=1.
- en=0: state, prev, run counters and counters hold; err_pulse=0.
- Match definition: count_in == (prev+1) mod 2^WIDTH. Wrap from 2^WIDTH-1 to 0 is a match.
- States:
  - IDLE: on en, prev<=count_in, good_run<=0, go ACQ.
  - ACQ:
    - on en with match: good_run++. If good_run+1==LOCK_CNT, go LOCKED and clear bad_run.
    - on en with mismatch: good_run<=0, stay in ACQ.
    - prev<=count_in on every sample.
  - LOCKED:
    - on en with match: bad_run<=0. If prev==2^WIDTH-1, wrap_count++.
    - on en with mismatch: err_pulse<=1, err_count++, bad_run++. If bad_run+1==LOSS_CNT, go ACQ with good_run<=0.
    - prev<=count_in on every sample (resync to received value, so a single glitch costs one error).
- locked is high exactly while state==LOCKED.
- expected <= (count_in+1) mod 2^WIDTH on every sample in any state; it holds when en=0.
- Counters saturate at 2^ERR_W-1 and never wrap.
- err_clr and a new error in the same cycle: err_count<=1. err_clr alone: err_count<=0. err_clr does not affect state or wrap_count.
- Reset mid-lock: locked falls and the counters clear at that edge. Reacquisition restarts from IDLE.
- Latency: lock asserts at the edge of sample LOCK_CNT+1 counted from IDLE. err_pulse asserts on the edge that samples the bad value.

Test Plan:
- rst=1 for 2 cycles, then en=1 with count_in 0,1,2,3 -> locked=0 after samples 0..2, locked=1 after sample 3; err_count=0; expected=4.
- Locked, feed 13,14,15,0,1 -> no err_pulse; wrap_count=1; expected=2.
- Locked, feed 5,6,9,10,11 -> single err_pulse at the edge sampling 9; err_count=1; locked stays 1 (LOSS_CNT=2); 10 and 11 match.
- Locked, feed 5,9,2,3,4,5 -> err_pulse on 9 and on 2; err_count=+2; locked=0 after 2; locked=1 again after 5.
- ERR_W=2 build, locked, 6 isolated glitches separated by good samples -> err_count saturates at 3. Then err_clr=1 on a glitch cycle -> err_count=1.
- Locked, en=0 for 5 cycles mid-sequence, then resume with the next value -> no error and outputs held. Assert rst while locked -> locked=0, err_count=0, wrap_count=0 next edge; refeed 0..3 -> relock.
